// File: rtl/time_keeper_if.sv
// Signal bundle between the adjust stage / buttons and the time_keeper core.
// The master modport drives the edits and button pulses; the slave modport is the core.
interface time_keeper_if;
    logic       adjust_mode;
    logic [1:0] adjusted;
    logic [4:0] time_hours_in;
    logic [5:0] time_minutes_in;
    logic [4:0] alarm_hours_in;
    logic [5:0] alarm_minutes_in;
    logic       alarm_stop;
    logic       alarm_snooze;
    logic [4:0] time_hours;
    logic [5:0] time_minutes;
    logic [5:0] time_seconds;
    logic [4:0] alarm_hours;
    logic [5:0] alarm_minutes;
    logic       sec_pulse;
    logic       alarm_ringing;

    modport master (
        output adjust_mode, adjusted, time_hours_in, time_minutes_in,
               alarm_hours_in, alarm_minutes_in, alarm_stop, alarm_snooze,
        input  time_hours, time_minutes, time_seconds, alarm_hours,
               alarm_minutes, sec_pulse, alarm_ringing
    );

    modport slave (
        input  adjust_mode, adjusted, time_hours_in, time_minutes_in,
               alarm_hours_in, alarm_minutes_in, alarm_stop, alarm_snooze,
        output time_hours, time_minutes, time_seconds, alarm_hours,
               alarm_minutes, sec_pulse, alarm_ringing
    );
endinterface

// File: rtl/time_keeper.sv
// Alarm-clock core: HH:MM:SS counter, stored alarm and ringing state machine.
// Optional snooze state is compiled in with TIME_KEEPER_SNOOZE_EN.
module time_keeper #(
    parameter int TICKS_PER_SEC  = 100000000,
    parameter int RING_SECONDS   = 60,
    parameter int SNOOZE_MINUTES = 5
) (
    input  logic         clk,
    input  logic         reset,
    time_keeper_if.slave bus
);
    localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0] PRESC_TC  = PW'(TICKS_PER_SEC - 1);
    localparam logic [31:0]   RING_LAST = 32'(RING_SECONDS - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RINGING = 2'd1,
        ST_ACKED   = 2'd2
`ifdef TIME_KEEPER_SNOOZE_EN
        , ST_SNOOZE = 2'd3
`endif
    } state_t;

    logic [PW-1:0] r_presc;
    logic [4:0]    r_hours;
    logic [5:0]    r_minutes;
    logic [5:0]    r_seconds;
    logic [4:0]    r_alarm_hours;
    logic [5:0]    r_alarm_minutes;
    logic          r_sec_pulse;
    logic          r_ringing;
    logic          r_adjust_prev;
    logic [31:0]   r_cnt;
    state_t        r_state;

    logic w_tick;
    logic w_time_load;
    logic w_alarm_load;
    logic w_match;
    logic w_adjust_rise;

    assign w_tick        = (r_presc == PRESC_TC) && !bus.adjust_mode;
    assign w_time_load   = bus.adjust_mode && bus.adjusted[0] &&
                           (bus.time_hours_in <= 5'd23) && (bus.time_minutes_in <= 6'd59);
    assign w_alarm_load  = bus.adjust_mode && bus.adjusted[1] &&
                           (bus.alarm_hours_in <= 5'd23) && (bus.alarm_minutes_in <= 6'd59);
    assign w_match       = (r_hours == r_alarm_hours) && (r_minutes == r_alarm_minutes);
    assign w_adjust_rise = bus.adjust_mode && !r_adjust_prev;

    // Prescaler, time counter and alarm registers; a valid load also restarts the second.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_presc         <= '0;
            r_hours         <= '0;
            r_minutes       <= '0;
            r_seconds       <= '0;
            r_alarm_hours   <= '0;
            r_alarm_minutes <= '0;
            r_sec_pulse     <= 1'b0;
        end else begin
            r_sec_pulse <= w_tick;
            if (w_time_load) begin
                r_hours   <= bus.time_hours_in;
                r_minutes <= bus.time_minutes_in;
                r_seconds <= '0;
                r_presc   <= '0;
            end else if (!bus.adjust_mode) begin
                if (r_presc == PRESC_TC) begin
                    r_presc <= '0;
                    if (r_seconds == 6'd59) begin
                        r_seconds <= '0;
                        if (r_minutes == 6'd59) begin
                            r_minutes <= '0;
                            r_hours   <= (r_hours == 5'd23) ? 5'd0 : r_hours + 5'd1;
                        end else begin
                            r_minutes <= r_minutes + 6'd1;
                        end
                    end else begin
                        r_seconds <= r_seconds + 6'd1;
                    end
                end else begin
                    r_presc <= r_presc + PW'(1);
                end
            end
            if (w_alarm_load) begin
                r_alarm_hours   <= bus.alarm_hours_in;
                r_alarm_minutes <= bus.alarm_minutes_in;
            end
        end
    end

    // Alarm FSM. ACKED blocks a retrigger until the matching minute has passed.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_ACKED;
            r_ringing     <= 1'b0;
            r_cnt         <= '0;
            r_adjust_prev <= 1'b0;
        end else begin
            r_adjust_prev <= bus.adjust_mode;
            case (r_state)
                ST_IDLE: begin
                    if (w_match && (r_seconds == 6'd0) && !bus.adjust_mode) begin
                        r_state   <= ST_RINGING;
                        r_ringing <= 1'b1;
                        r_cnt     <= '0;
                    end
                end
                ST_RINGING: begin
                    if (bus.alarm_stop || w_adjust_rise || (w_tick && (r_cnt == RING_LAST))) begin
                        r_state   <= ST_ACKED;
                        r_ringing <= 1'b0;
                    end
`ifdef TIME_KEEPER_SNOOZE_EN
                    else if (bus.alarm_snooze) begin
                        r_state   <= ST_SNOOZE;
                        r_ringing <= 1'b0;
                        r_cnt     <= '0;
                    end
`endif
                    else if (w_tick) begin
                        r_cnt <= r_cnt + 32'd1;
                    end
                end
                ST_ACKED: begin
                    if (!w_match) begin
                        r_state <= ST_IDLE;
                    end
                end
`ifdef TIME_KEEPER_SNOOZE_EN
                ST_SNOOZE: begin
                    if (bus.alarm_stop || bus.adjust_mode) begin
                        r_state <= ST_ACKED;
                    end else if (w_tick) begin
                        if (r_cnt == 32'(SNOOZE_MINUTES * 60 - 1)) begin
                            r_state   <= ST_RINGING;
                            r_ringing <= 1'b1;
                            r_cnt     <= '0;
                        end else begin
                            r_cnt <= r_cnt + 32'd1;
                        end
                    end
                end
`endif
                default: begin
                    r_state   <= ST_ACKED;
                    r_ringing <= 1'b0;
                end
            endcase
        end
    end

`ifdef TIME_KEEPER_SNOOZE_EN
`else
    logic w_unused_snooze;
    assign w_unused_snooze = bus.alarm_snooze;
`endif

    assign bus.time_hours    = r_hours;
    assign bus.time_minutes  = r_minutes;
    assign bus.time_seconds  = r_seconds;
    assign bus.alarm_hours   = r_alarm_hours;
    assign bus.alarm_minutes = r_alarm_minutes;
    assign bus.sec_pulse     = r_sec_pulse;
    assign bus.alarm_ringing = r_ringing;
endmodule

// File: tb/tb_time_keeper.sv
// Directed bench for time_keeper with 4 ticks/s, 3 s ring and 1 min snooze.
// Expected values are hand-computed cycle counts relative to each load edge.
module tb_time_keeper;
    logic clk;
    logic reset;
    int   n_total;
    int   n_bad;

    time_keeper_if bus();

    time_keeper #(
        .TICKS_PER_SEC (4),
        .RING_SECONDS  (3),
        .SNOOZE_MINUTES(1)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end else begin
            $display("ok   %s = %0d", tag, obs);
        end
    endtask

    // Advance n rising edges, then settle 1 ns past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_time(input string tag, input int h, input int m, input int s);
        chk({tag, ".h"}, 32'(bus.time_hours), 32'(h));
        chk({tag, ".m"}, 32'(bus.time_minutes), 32'(m));
        chk({tag, ".s"}, 32'(bus.time_seconds), 32'(s));
    endtask

    task automatic load_time(input int h, input int m);
        bus.adjust_mode     = 1'b1;
        bus.adjusted        = 2'b01;
        bus.time_hours_in   = 5'(h);
        bus.time_minutes_in = 6'(m);
        step(1);
        bus.adjust_mode = 1'b0;
        bus.adjusted    = 2'b00;
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;
        reset = 1'b1;
        bus.adjust_mode      = 1'b0;
        bus.adjusted         = 2'b00;
        bus.time_hours_in    = '0;
        bus.time_minutes_in  = '0;
        bus.alarm_hours_in   = '0;
        bus.alarm_minutes_in = '0;
        bus.alarm_stop       = 1'b0;
        bus.alarm_snooze     = 1'b0;
        step(3);
        chk_time("rst", 0, 0, 0);
        chk("rst.ah", 32'(bus.alarm_hours), 0);
        chk("rst.am", 32'(bus.alarm_minutes), 0);
        chk("rst.pulse", 32'(bus.sec_pulse), 0);
        chk("rst.ring", 32'(bus.alarm_ringing), 0);
        reset = 1'b0;

        // Rollover: 23:59:00 -> 00:00:00 after 60 ticks (240 clk)
        load_time(23, 59);
        chk_time("load2359", 23, 59, 0);
        step(3);
        chk("roll.pulse3", 32'(bus.sec_pulse), 0);
        step(1);
        chk("roll.pulse4", 32'(bus.sec_pulse), 1);
        chk("roll.s4", 32'(bus.time_seconds), 1);
        step(1);
        chk("roll.pulse5", 32'(bus.sec_pulse), 0);
        step(235);
        chk_time("roll240", 0, 0, 0);
        chk("roll.pulse240", 32'(bus.sec_pulse), 1);
        chk("roll.ring240", 32'(bus.alarm_ringing), 0);
        step(1);
        chk("midnight.ring", 32'(bus.alarm_ringing), 1);

        // Reset mid-ring
        reset = 1'b1;
        step(1);
        chk_time("rst2", 0, 0, 0);
        chk("rst2.ring", 32'(bus.alarm_ringing), 0);
        chk("rst2.pulse", 32'(bus.sec_pulse), 0);
        reset = 1'b0;
        step(8);
        chk_time("rst2.run", 0, 0, 2);
        chk("rst2.noring", 32'(bus.alarm_ringing), 0);

        // Invalid loads are ignored; valid alarm load lands next cycle
        bus.adjust_mode     = 1'b1;
        bus.adjusted        = 2'b01;
        bus.time_hours_in   = 5'd24;
        bus.time_minutes_in = 6'd10;
        step(1);
        chk_time("bad24", 0, 0, 2);
        bus.adjusted         = 2'b10;
        bus.alarm_hours_in   = 5'd7;
        bus.alarm_minutes_in = 6'd60;
        step(1);
        chk("bad60.ah", 32'(bus.alarm_hours), 0);
        chk("bad60.am", 32'(bus.alarm_minutes), 0);
        bus.alarm_minutes_in = 6'd30;
        step(1);
        chk("al0730.ah", 32'(bus.alarm_hours), 7);
        chk("al0730.am", 32'(bus.alarm_minutes), 30);
        chk_time("al0730.t", 0, 0, 2);

        // Trigger at 07:30:00 and stop
        load_time(7, 29);
        chk_time("load0729", 7, 29, 0);
        step(239);
        chk_time("pre0730", 7, 29, 59);
        chk("pre.ring", 32'(bus.alarm_ringing), 0);
        step(1);
        chk_time("t0730", 7, 30, 0);
        chk("t0730.ring", 32'(bus.alarm_ringing), 0);
        step(1);
        chk("trig.ring", 32'(bus.alarm_ringing), 1);
        bus.alarm_stop = 1'b1;
        step(1);
        bus.alarm_stop = 1'b0;
        chk("stop.ring", 32'(bus.alarm_ringing), 0);
        step(200);
        chk("stop.hold", 32'(bus.alarm_ringing), 0);
        chk("stop.min", 32'(bus.time_minutes), 30);
        step(38);
        chk_time("t0731", 7, 31, 0);

        // Next occurrence of 07:30 rings again, then auto-stops after 3 ticks
        load_time(7, 30);
        chk("again.ring0", 32'(bus.alarm_ringing), 0);
        step(1);
        chk("again.ring1", 32'(bus.alarm_ringing), 1);
        step(10);
        chk("auto.ring11", 32'(bus.alarm_ringing), 1);
        chk("auto.s11", 32'(bus.time_seconds), 2);
        step(1);
        chk("auto.ring12", 32'(bus.alarm_ringing), 0);
        chk("auto.s12", 32'(bus.time_seconds), 3);
        step(188);
        chk("acked.ring", 32'(bus.alarm_ringing), 0);
        step(40);
        chk_time("t0731b", 7, 31, 0);

        // Snooze while ringing
        load_time(7, 30);
        step(1);
        chk("snz.ring1", 32'(bus.alarm_ringing), 1);
        bus.alarm_snooze = 1'b1;
        step(1);
        bus.alarm_snooze = 1'b0;
`ifdef TIME_KEEPER_SNOOZE_EN
        chk("snz.quiet", 32'(bus.alarm_ringing), 0);
        step(237);
        chk("snz.quiet239", 32'(bus.alarm_ringing), 0);
        step(1);
        chk("snz.rering", 32'(bus.alarm_ringing), 1);
`else
        chk("snz.ignored", 32'(bus.alarm_ringing), 1);
`endif
        bus.alarm_stop = 1'b1;
        step(1);
        bus.alarm_stop = 1'b0;
        chk("snz.stop", 32'(bus.alarm_ringing), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule

// File: doc/time_keeper.md
# time_keeper

Real-time core of the alarm clock: counts HH:MM:SS from the system clock, holds the stored alarm time, and drives the alarm-ringing state machine. It sits directly downstream of the adjust stage. It loads edited hour/minute values when the `adjusted` flags are raised, and feeds its current time and alarm back as that stage's `input_*` values and to the display path.

## Interface
- `TICKS_PER_SEC`, 100000000, clk cycles per second; prescaler terminal count is `TICKS_PER_SEC-1`.
- `RING_SECONDS`, 60, seconds the alarm rings before auto-stop.
- `SNOOZE_MINUTES`, 5, snooze length (used only with `TIME_KEEPER_SNOOZE_EN`).

Ports:
- `clk`  in  1  system clock; one clock domain only.
- `reset`  in  1  synchronous, active-high.
- `adjust_mode`  in  1  high while the adjust stage is active.
- `adjusted`  in  2  bit0: edited time differs; bit1: edited alarm differs.
- `time_hours_in`  in  5  edited hours, 0-23.
- `time_minutes_in`  in  6  edited minutes, 0-59.
- `alarm_hours_in`  in  5  edited alarm hours, 0-23.
- `alarm_minutes_in`  in  6  edited alarm minutes, 0-59.
- `alarm_stop`  in  1  one-cycle pulse from the debounced button.
- `alarm_snooze`  in  1  one-cycle pulse from the debounced button.
- `time_hours`  out  5  current hours.
- `time_minutes`  out  6  current minutes.
- `time_seconds`  out  6  current seconds.
- `alarm_hours`  out  5  stored alarm hours.
- `alarm_minutes`  out  6  stored alarm minutes.
- `sec_pulse`  out  1  one-cycle strobe on every seconds increment.
- `alarm_ringing`  out  1  high in `RINGING`.

## Operation
- **Prescaler**
  - Counts 0..`TICKS_PER_SEC-1`, then wraps to 0.
  - A tick is the cycle at terminal count while `adjust_mode`=0.
  - While `adjust_mode`=1 the prescaler holds, and time does not advance.
- **Time counter** (on each tick)
  - Seconds 0..59. On wrap, minutes increment, 0..59.
  - On minutes wrap, hours increment, 0..23.
  - 23:59:59 advances to 00:00:00.
- **Time load**
  - Occurs when `adjust_mode`=1 and `adjusted[0]`=1, every such cycle.
  - Hours and minutes take the `_in` values; seconds and prescaler are cleared to 0.
  - If hours >23 or minutes >59, the load is ignored and registers keep their old values.
- **Alarm load**
  - Same rule using `adjusted[1]` and the `alarm_*_in` values.
  - Seconds and prescaler are untouched.
- **Alarm FSM**
  - Match condition: `time_hours`==`alarm_hours` and `time_minutes`==`alarm_minutes`.
  - `IDLE` -> `RINGING`: match, `time_seconds`==0, and `adjust_mode`=0.
  - `RINGING` -> `ACKED`:
    - `alarm_stop`,
    - `adjust_mode` rising to 1, or
    - `RING_SECONDS` ticks elapsed. The ring counter clears on entry to `RINGING`.
  - `ACKED` -> `IDLE`: match is false. This prevents a retrigger within the same minute.
- **Reset**
  - State is `ACKED`, so the initial 00:00 time/alarm match does not ring.
  - Earliest ring after reset is the next 00:00:00 with alarm still at 00:00.
- **Simultaneous events**
  - Load and tick in the same cycle: load wins; the tick is impossible anyway because `adjust_mode` blocks it.
  - `alarm_stop` and ring timeout in the same cycle: `ACKED`.
  - `alarm_stop` and `alarm_snooze` in the same cycle: stop wins.
  - `alarm_stop` outside `RINGING`: ignored.

## Timing
- **Reset values**
  - All time and alarm outputs: 0.
  - `sec_pulse`=0, `alarm_ringing`=0, FSM state `ACKED`.
  - `reset` overrides everything, including mid-ring and mid-load.
- **Latency**
  - Registers update on the clk edge following the tick cycle; `sec_pulse` is high for the cycle after that edge.
  - Load visible on outputs 1 cycle after `adjust_mode`&`adjusted[i]` is sampled high.
  - `alarm_ringing` rises 1 cycle after the time registers show HH:MM:00 matching.
  - `alarm_ringing` falls 1 cycle after an `alarm_stop` pulse is sampled.
- **Output type:** all outputs are registered; no combinational input-to-output paths.

## Configuration
- **Macro:** `TIME_KEEPER_SNOOZE_EN`.
- **Defined:**
  - Adds state `SNOOZE`.
  - `RINGING` -> `SNOOZE` on `alarm_snooze`.
  - `SNOOZE` -> `RINGING` after `SNOOZE_MINUTES*60` ticks, with the ring counter cleared.
  - `SNOOZE` -> `ACKED` on `alarm_stop` or `adjust_mode`=1.
  - `alarm_ringing`=0 in `SNOOZE`.
- **Undefined:** `alarm_snooze` is ignored (port remains). The FSM has only `IDLE`, `RINGING` and `ACKED`.

## Test plan
All scenarios run with `TICKS_PER_SEC`=4 and `RING_SECONDS`=3.
- **Rollover:** load 23:59 via `adjust_mode`=1, `adjusted`=01; release; after 60 ticks (240 clk) -> 00:00:00, one `sec_pulse` per 4 clk.
- **Invalid load:** load time 24:10 -> registers unchanged. Load alarm 07:60 -> alarm unchanged. Load alarm 07:30 -> `alarm_hours`=7, `alarm_minutes`=30 the next cycle.
- **Alarm trigger and stop:** alarm 07:30, time 07:29:58.
  - Ring rises 1 cycle after 07:30:00.
  - `alarm_stop` pulse -> ring low next cycle, no re-ring during 07:30.
  - Alarm rings again the next day.
- **Auto-stop:** same setup, no stop -> `alarm_ringing` high exactly 3 ticks, then low; state `ACKED` until 07:31.
- **Reset:** assert `reset` mid-ring -> all outputs 0 next cycle, no ring at time 00:00:00.
- **Snooze** (macro defined, `SNOOZE_MINUTES`=1): `alarm_snooze` while ringing -> low for 60 ticks, then ringing again; `alarm_stop` -> `ACKED`.
